// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM stage encoding and
// the board-level default debounce length.
package operand_loader_pkg;

  typedef enum logic [1:0] {
    S_WAIT_A = 2'b00,
    S_WAIT_B = 2'b01,
    S_READY  = 2'b10
  } stage_t;

  localparam logic [19:0] DEFAULT_DEBOUNCE_CYCLES = 20'd1_000_000;

endpackage

// File: rtl/operand_loader_btn_debounce_pulse.sv
// Raw push-button conditioner: 2-flop synchronizer, counter debounce and a
// registered single-cycle pulse on each accepted press.
module btn_debounce_pulse
  import operand_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'(DEFAULT_DEBOUNCE_CYCLES),
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      // Any sample agreeing with the accepted level restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Captures operand A then B from a shared switch bank on debounced load
// presses; a debounced clear press empties the pair.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 32'(DEFAULT_DEBOUNCE_CYCLES),
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             valid,
  output logic [1:0]       stage
);

  logic load_p;
  logic clear_p;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_db (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_load),
    .pulse  (load_p)
  );

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clear_db (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_clear),
    .pulse  (clear_p)
  );

  stage_t           state;
  stage_t           state_next;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic             valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_WAIT_A;
      a_out <= '0;
      b_out <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      a_out <= a_next;
      b_out <= b_next;
      valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    a_next     = a_out;
    b_next     = b_out;
    valid_next = valid;
    case (state)
      S_WAIT_A: begin
        if (load_p) begin
          a_next     = sw;
          state_next = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (load_p) begin
          b_next     = sw;
          valid_next = 1'b1;
          state_next = S_READY;
        end
      end
      S_READY: begin
        if (load_p) begin
          a_next     = sw;
          valid_next = 1'b0;
          state_next = S_WAIT_B;
        end
      end
      default: begin
        state_next = S_WAIT_A;
        a_next     = '0;
        b_next     = '0;
        valid_next = 1'b0;
      end
    endcase
    // Clear overrides whatever load decided above.
    if (clear_p) begin
      state_next = S_WAIT_A;
      a_next     = '0;
      b_next     = '0;
      valid_next = 1'b0;
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with a short debounce length and a
// sample-history reference model of the button path and operand sequencing.
module tb_operand_loader;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       valid;
  logic [1:0] stage;

  int compared;
  int mismatched;

  // reference model state
  logic [N:0] hl, hc;      // raw sample history per button, [0] newest
  logic       ll, lc;      // accepted levels
  logic       rl, rc;      // rise seen on the last edge
  logic       mp_l, mp_c;  // pulses visible this cycle
  logic [3:0] m_a, m_b;
  logic       m_valid;
  logic [1:0] m_stage;

  operand_loader #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_clear(btn_clear),
    .a_out    (a_out),
    .b_out    (b_out),
    .valid    (valid),
    .stage    (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A level is accepted once N consecutive synchronized samples disagree with it.
  task automatic btn_model(input logic r, input logic raw, inout logic [N:0] h,
                           inout logic lvl, inout logic rise, inout logic p);
    logic flip;
    if (r) begin
      h = '0; lvl = 1'b0; rise = 1'b0; p = 1'b0;
    end else begin
      flip = 1'b1;
      for (int i = 1; i <= N; i++) if (h[i] == lvl) flip = 1'b0;
      p    = rise;
      rise = flip && !lvl;
      if (flip) lvl = !lvl;
      h = {h[N-1:0], raw};
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic cl, input logic [3:0] s);
    @(negedge clk);
    rst = r; btn_load = ld; btn_clear = cl; sw = s;
    @(posedge clk);
    if (r) begin
      m_a = '0; m_b = '0; m_valid = 1'b0; m_stage = 2'd0;
    end else if (mp_c) begin
      m_a = '0; m_b = '0; m_valid = 1'b0; m_stage = 2'd0;
    end else if (mp_l) begin
      case (m_stage)
        2'd0: begin m_a = s; m_stage = 2'd1; end
        2'd1: begin m_b = s; m_valid = 1'b1; m_stage = 2'd2; end
        default: begin m_a = s; m_valid = 1'b0; m_stage = 2'd1; end
      endcase
    end
    btn_model(r, ld, hl, ll, rl, mp_l);
    btn_model(r, cl, hc, lc, rc, mp_c);
    #1;
  endtask

  task automatic press(input logic ld, input logic cl, input logic [3:0] s);
    repeat (10) step(1'b0, ld, cl, s);
    repeat (10) step(1'b0, 1'b0, 1'b0, s);
  endtask

  task automatic test_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, 4'h0);
    compared++;
    if ({a_out, b_out, valid, stage} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_state: got a=%h b=%h v=%b st=%b, want all zero", a_out, b_out, valid, stage);
    end
    repeat (2) step(1'b1, 1'b1, 1'b0, 4'h5);
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'h5);
      compared++;
      if (stage !== ((c >= 8) ? 2'd1 : 2'd0) || stage !== m_stage) begin
        mismatched++;
        $display("FAIL held_through_reset c=%0d: got st=%b, want %b", c, stage, (c >= 8) ? 2'd1 : 2'd0);
      end
    end
    compared++;
    if (a_out !== 4'h5) begin
      mismatched++;
      $display("FAIL held_capture: got a=%h, want 5", a_out);
    end
    repeat (10) step(1'b0, 1'b0, 1'b0, 4'h5);
  endtask

  task automatic test_full_load();
    step(1'b1, 1'b0, 1'b0, 4'h0);
    press(1'b1, 1'b0, 4'h9);
    compared++;
    if ({a_out, valid, stage} !== {4'h9, 1'b0, 2'd1}) begin
      mismatched++;
      $display("FAIL load_a: got a=%h v=%b st=%b, want a=9 v=0 st=01", a_out, valid, stage);
    end
    press(1'b1, 1'b0, 4'h3);
    compared++;
    if ({a_out, b_out, valid, stage} !== {4'h9, 4'h3, 1'b1, 2'd2}) begin
      mismatched++;
      $display("FAIL load_b: got a=%h b=%h v=%b st=%b, want a=9 b=3 v=1 st=10", a_out, b_out, valid, stage);
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    pat = 9'b101101110;  // first sample is the MSB
    for (int i = 8; i >= 0; i--) step(1'b0, pat[i], 1'b0, 4'hC);
    repeat (8) step(1'b0, 1'b0, 1'b0, 4'hC);
    compared++;
    if ({a_out, b_out, valid, stage} !== {4'h9, 4'h3, 1'b1, 2'd2}) begin
      mismatched++;
      $display("FAIL bounce: got a=%h b=%h v=%b st=%b, want a=9 b=3 v=1 st=10", a_out, b_out, valid, stage);
    end
  endtask

  task automatic test_reload();
    press(1'b1, 1'b0, 4'hF);
    compared++;
    if ({a_out, b_out, valid, stage} !== {4'hF, 4'h3, 1'b0, 2'd1}) begin
      mismatched++;
      $display("FAIL reload: got a=%h b=%h v=%b st=%b, want a=f b=3 v=0 st=01", a_out, b_out, valid, stage);
    end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 20; c++) begin
      step(1'b0, c < 10, c < 10, 4'h7);
      compared++;
      if (a_out === 4'h7 || b_out === 4'h7) begin
        mismatched++;
        $display("FAIL simul_no_capture c=%0d: got a=%h b=%h, want neither 7", c, a_out, b_out);
      end
    end
    compared++;
    if ({a_out, b_out, valid, stage} !== 11'd0) begin
      mismatched++;
      $display("FAIL simul_clear: got a=%h b=%h v=%b st=%b, want all zero", a_out, b_out, valid, stage);
    end
  endtask

  task automatic test_reset_mid();
    press(1'b1, 1'b0, 4'h9);
    press(1'b1, 1'b0, 4'h3);
    repeat (3) step(1'b0, 1'b1, 1'b0, 4'hA);
    step(1'b1, 1'b1, 1'b0, 4'hA);
    compared++;
    if ({a_out, b_out, valid, stage} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_mid: got a=%h b=%h v=%b st=%b, want all zero", a_out, b_out, valid, stage);
    end
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, 1'b1, 1'b0, 4'hA);
      compared++;
      if (stage !== ((c >= 8) ? 2'd1 : 2'd0)) begin
        mismatched++;
        $display("FAIL restart_count c=%0d: got st=%b, want %b", c, stage, (c >= 8) ? 2'd1 : 2'd0);
      end
    end
    repeat (10) step(1'b0, 1'b0, 1'b0, 4'hA);
  endtask

  task automatic test_random();
    logic ld, cl, r;
    ld = 1'b0; cl = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) ld = !ld;
      if ($urandom_range(11) == 0) cl = !cl;
      r = ($urandom_range(149) == 0);
      step(r, ld, cl, 4'($urandom));
      compared++;
      if ({a_out, b_out, valid, stage} !== {m_a, m_b, m_valid, m_stage}) begin
        mismatched++;
        $display("FAIL random c=%0d: got a=%h b=%h v=%b st=%b, want a=%h b=%h v=%b st=%b",
                 c, a_out, b_out, valid, stage, m_a, m_b, m_valid, m_stage);
      end
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; btn_load = 1'b0; btn_clear = 1'b0; sw = '0;
    hl = '0; hc = '0; ll = 1'b0; lc = 1'b0; rl = 1'b0; rc = 1'b0;
    mp_l = 1'b0; mp_c = 1'b0;
    m_a = '0; m_b = '0; m_valid = 1'b0; m_stage = 2'd0;
    test_reset();
    test_full_load();
    test_bounce();
    test_reload();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
